// File: rtl/mvau_weight_loader_pkg.sv
// Shared types and default geometry for the MVAU weight loader.
package mvau_weight_loader_pkg;

    localparam int unsigned DEF_SIMD         = 2;
    localparam int unsigned DEF_PE           = 2;
    localparam int unsigned DEF_TW           = 1;
    localparam int unsigned DEF_WMEM_DEPTH   = 4;
    localparam int unsigned DEF_WMEM_ADDR_BW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } wld_state_t;

    // Counter width that stays at least one bit for a single-entry range.
    function automatic int unsigned cnt_bw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvau_weight_loader_if.sv
// Control, weight stream and weight-memory write port of the loader.
interface mvau_weight_loader_if #(
    parameter int unsigned SIMD         = 2,
    parameter int unsigned TW           = 1,
    parameter int unsigned PE           = 2,
    parameter int unsigned WMEM_ADDR_BW = 2
);
    logic                    load_start;
    logic                    load_abort;
    logic                    in_wgt_v;
    logic                    in_wgt_rdy;
    logic [SIMD*TW-1:0]      in_wgt;
    logic [PE-1:0]           wmem_wr_en;
    logic [WMEM_ADDR_BW-1:0] wmem_wr_addr;
    logic [SIMD*TW-1:0]      wmem_wr_data;
    logic                    load_busy;
    logic                    load_done;

    modport master (
        output load_start, load_abort, in_wgt_v, in_wgt,
        input  in_wgt_rdy, wmem_wr_en, wmem_wr_addr, wmem_wr_data, load_busy, load_done
    );

    modport slave (
        input  load_start, load_abort, in_wgt_v, in_wgt,
        output in_wgt_rdy, wmem_wr_en, wmem_wr_addr, wmem_wr_data, load_busy, load_done
    );
endinterface

// File: rtl/mvau_weight_loader_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the increment that rolls over.
module mvau_weight_loader_wrap_counter #(
    parameter int unsigned W   = 2,
    parameter int unsigned MAX = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    logic [W-1:0] r_cnt;

    assign wrap = inc && (r_cnt == W'(MAX));
    assign cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || wrap) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end
endmodule

// File: rtl/mvau_weight_loader.sv
// Writes a PE-interleaved weight stream into the PE weight memories, one word per transfer,
// with a one-cycle registered write port and a done pulse on the final write.
module mvau_weight_loader
    import mvau_weight_loader_pkg::*;
#(
    parameter int unsigned SIMD         = DEF_SIMD,
    parameter int unsigned PE           = DEF_PE,
    parameter int unsigned TW           = DEF_TW,
    parameter int unsigned WMEM_DEPTH   = DEF_WMEM_DEPTH,
    parameter int unsigned WMEM_ADDR_BW = DEF_WMEM_ADDR_BW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mvau_weight_loader_if.slave  bus
);
    localparam int unsigned PE_BW  = cnt_bw(PE);
    localparam int unsigned WORD_W = SIMD * TW;

    wld_state_t              r_state;
    wld_state_t              w_state_nxt;
    logic                    w_xfer;
    logic                    w_pe_wrap;
    logic                    w_last;
    logic [PE_BW-1:0]        w_pe_cnt;
    logic [WMEM_ADDR_BW-1:0] w_addr_cnt;

    logic [PE-1:0]           r_wr_en;
    logic [WMEM_ADDR_BW-1:0] r_wr_addr;
    logic [WORD_W-1:0]       r_wr_data;
    logic                    r_done;

    // Abort masks ready so a word offered in the abort cycle is never written.
    assign bus.in_wgt_rdy = (r_state == LOAD) && !bus.load_abort;
    assign w_xfer         = bus.in_wgt_v && bus.in_wgt_rdy;

    mvau_weight_loader_wrap_counter #(.W(PE_BW), .MAX(PE - 1)) u_pe_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.load_abort),
        .inc   (w_xfer),
        .cnt   (w_pe_cnt),
        .wrap  (w_pe_wrap)
    );

    // Address wrap coincides with the final word of the load.
    mvau_weight_loader_wrap_counter #(.W(WMEM_ADDR_BW), .MAX(WMEM_DEPTH - 1)) u_addr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.load_abort),
        .inc   (w_pe_wrap),
        .cnt   (w_addr_cnt),
        .wrap  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.load_start && !bus.load_abort) w_state_nxt = LOAD;
            LOAD: if (bus.load_abort || w_last)          w_state_nxt = IDLE;
            default:                                     w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= w_xfer ? (PE'(1) << w_pe_cnt) : '0;
            r_done  <= w_last;
            if (w_xfer) begin
                r_wr_addr <= w_addr_cnt;
                r_wr_data <= bus.in_wgt;
            end
        end
    end

    assign bus.wmem_wr_en   = r_wr_en;
    assign bus.wmem_wr_addr = r_wr_addr;
    assign bus.wmem_wr_data = r_wr_data;
    assign bus.load_done    = r_done;
    assign bus.load_busy    = (r_state == LOAD);
endmodule

// File: tb/tb_mvau_weight_loader.sv
// Directed bench for mvau_weight_loader: PE=2/DEPTH=4 main instance and a PE=1/DEPTH=3 instance.
module tb_mvau_weight_loader;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mvau_weight_loader_if #(.SIMD(2), .TW(4), .PE(2), .WMEM_ADDR_BW(2)) b0 ();
    mvau_weight_loader_if #(.SIMD(2), .TW(4), .PE(1), .WMEM_ADDR_BW(2)) b1 ();

    mvau_weight_loader #(.SIMD(2), .PE(2), .TW(4), .WMEM_DEPTH(4), .WMEM_ADDR_BW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    mvau_weight_loader #(.SIMD(2), .PE(1), .TW(4), .WMEM_DEPTH(3), .WMEM_ADDR_BW(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] en, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] done);
        chk({tag, "_en"},   32'(b0.wmem_wr_en),   en);
        chk({tag, "_addr"}, 32'(b0.wmem_wr_addr), addr);
        chk({tag, "_data"}, 32'(b0.wmem_wr_data), data);
        chk({tag, "_done"}, 32'(b0.load_done),    done);
    endtask

    task automatic start0();
        b0.load_start = 1'b1;
        tick();
        b0.load_start = 1'b0;
        chk("start_busy", 32'(b0.load_busy),  32'd1);
        chk("start_rdy",  32'(b0.in_wgt_rdy), 32'd1);
    endtask

    // Eight back-to-back words; optionally pulse load_start alongside word pulse_idx.
    task automatic full_load(input string tag, input logic [7:0] base, input int pulse_idx);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_busy"}, 32'(b0.load_busy), 32'd1);
            b0.in_wgt_v   = 1'b1;
            b0.in_wgt     = 8'(base + 8'(k));
            b0.load_start = (k == pulse_idx);
            tick();
            chk_wr(tag, (k % 2 == 0) ? 32'd1 : 32'd2, 32'(k / 2), 32'(base + 8'(k)),
                   (k == 7) ? 32'd1 : 32'd0);
        end
        b0.in_wgt_v   = 1'b0;
        b0.load_start = 1'b0;
        chk({tag, "_rdy_after"},  32'(b0.in_wgt_rdy), 32'd0);
        chk({tag, "_busy_after"}, 32'(b0.load_busy),  32'd0);
        tick();
        chk({tag, "_en_after"},   32'(b0.wmem_wr_en), 32'd0);
        chk({tag, "_done_after"}, 32'(b0.load_done),  32'd0);
    endtask

    initial begin
        logic [15:0] pat;
        int          n;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        b0.load_start = 1'b0; b0.load_abort = 1'b0; b0.in_wgt_v = 1'b0; b0.in_wgt = '0;
        b1.load_start = 1'b0; b1.load_abort = 1'b0; b1.in_wgt_v = 1'b0; b1.in_wgt = '0;

        // Reset values
        #3;
        chk("rst_en",   32'(b0.wmem_wr_en),   32'd0);
        chk("rst_addr", 32'(b0.wmem_wr_addr), 32'd0);
        chk("rst_data", 32'(b0.wmem_wr_data), 32'd0);
        chk("rst_busy", 32'(b0.load_busy),    32'd0);
        chk("rst_done", 32'(b0.load_done),    32'd0);
        chk("rst_rdy",  32'(b0.in_wgt_rdy),   32'd0);
        chk("rst1_en",  32'(b1.wmem_wr_en),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: full load, continuous valid
        start0();
        full_load("s1", 8'h00, -1);

        // 2: gapped valid stream
        start0();
        pat = 16'b0110_1011_0100_1101;
        n   = 0;
        for (int i = 0; i < 32 && n < 8; i++) begin
            chk("s2_busy", 32'(b0.load_busy), 32'd1);
            b0.in_wgt_v = pat[i % 16];
            b0.in_wgt   = 8'(8'h20 + 8'(n));
            tick();
            if (pat[i % 16]) begin
                chk_wr("s2", (n % 2 == 0) ? 32'd1 : 32'd2, 32'(n / 2), 32'(8'h20 + 8'(n)),
                       (n == 7) ? 32'd1 : 32'd0);
                n++;
            end else begin
                chk("s2_gap_en", 32'(b0.wmem_wr_en), 32'd0);
            end
        end
        b0.in_wgt_v = 1'b0;
        chk("s2_rdy_after", 32'(b0.in_wgt_rdy), 32'd0);
        tick();

        // 3: abort after three words, then restart from memory 0 / address 0
        start0();
        for (int k = 0; k < 3; k++) begin
            b0.in_wgt_v = 1'b1;
            b0.in_wgt   = 8'(8'h30 + 8'(k));
            tick();
            chk_wr("s3", (k % 2 == 0) ? 32'd1 : 32'd2, 32'(k / 2), 32'(8'h30 + 8'(k)), 32'd0);
        end
        b0.in_wgt     = 8'h33;
        b0.load_abort = 1'b1;
        #1;
        chk("s3_abort_rdy", 32'(b0.in_wgt_rdy), 32'd0);
        tick();
        b0.load_abort = 1'b0;
        b0.in_wgt_v   = 1'b0;
        chk_wr("s3_abort", 32'd0, 32'd1, 32'h32, 32'd0);
        chk("s3_abort_busy", 32'(b0.load_busy), 32'd0);
        tick();
        chk("s3_nodone", 32'(b0.load_done), 32'd0);
        start0();
        b0.in_wgt_v = 1'b1;
        b0.in_wgt   = 8'h3A;
        tick();
        chk_wr("s3_restart", 32'd1, 32'd0, 32'h3A, 32'd0);
        b0.in_wgt_v   = 1'b0;
        b0.load_abort = 1'b1;
        tick();
        b0.load_abort = 1'b0;

        // 4: asynchronous reset mid-load
        start0();
        for (int k = 0; k < 2; k++) begin
            b0.in_wgt_v = 1'b1;
            b0.in_wgt   = 8'(8'h41 + 8'(k));
            tick();
        end
        chk("s4_pre_en", 32'(b0.wmem_wr_en), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s4_rst_en",   32'(b0.wmem_wr_en),   32'd0);
        chk("s4_rst_addr", 32'(b0.wmem_wr_addr), 32'd0);
        chk("s4_rst_data", 32'(b0.wmem_wr_data), 32'd0);
        chk("s4_rst_busy", 32'(b0.load_busy),    32'd0);
        chk("s4_rst_rdy",  32'(b0.in_wgt_rdy),   32'd0);
        chk("s4_rst_done", 32'(b0.load_done),    32'd0);
        b0.in_wgt_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start0();
        full_load("s4", 8'h50, -1);

        // 5: load_start during LOAD ignored; start with abort in IDLE stays idle
        start0();
        full_load("s5", 8'h60, 3);
        b0.load_start = 1'b1;
        b0.load_abort = 1'b1;
        tick();
        b0.load_start = 1'b0;
        b0.load_abort = 1'b0;
        chk("s5_idle_busy", 32'(b0.load_busy),  32'd0);
        chk("s5_idle_rdy",  32'(b0.in_wgt_rdy), 32'd0);
        b0.in_wgt_v = 1'b1;
        b0.in_wgt   = 8'h77;
        tick();
        b0.in_wgt_v = 1'b0;
        chk("s5_idle_en", 32'(b0.wmem_wr_en), 32'd0);

        // 6: PE=1, depth 3
        b1.load_start = 1'b1;
        tick();
        b1.load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("s6_busy", 32'(b1.load_busy), 32'd1);
            b1.in_wgt_v = 1'b1;
            b1.in_wgt   = 8'(8'h80 + 8'(k));
            tick();
            chk("s6_en",   32'(b1.wmem_wr_en),   32'd1);
            chk("s6_addr", 32'(b1.wmem_wr_addr), 32'(k));
            chk("s6_data", 32'(b1.wmem_wr_data), 32'(8'h80 + 8'(k)));
            chk("s6_done", 32'(b1.load_done),    (k == 2) ? 32'd1 : 32'd0);
        end
        b1.in_wgt_v = 1'b0;
        chk("s6_rdy_after",  32'(b1.in_wgt_rdy), 32'd0);
        chk("s6_busy_after", 32'(b1.load_busy),  32'd0);
        tick();
        chk("s6_en_after", 32'(b1.wmem_wr_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
